conv_read_addr_gen: RTL and testbench

Read-side sequencer of the convolution data loader. It walks one IFMap row at a time in the circular IFMap scratchpad and emits paired read addresses (IFMap element, filter element) for every sliding window × filter × tap. It gates each read on data availability and downstream stall. It pops the row-boundary FIFOs (start/end row pointers, supplied by the loader) when a row is finished.

---
 rtl/conv_read_addr_gen_pkg.sv | 18 +
 rtl/conv_read_addr_gen_circ_offset.sv | 37 +++
 rtl/conv_read_addr_gen.sv | 180 ++++++++++++++++++
 tb/tb_conv_read_addr_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_read_addr_gen_pkg.sv
// Purpose : shared types for the convolution read-address sequencer.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
package conv_read_addr_gen_pkg;

    // Row sequencing states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ROW = 2'd1,
        RUN      = 2'd2,
        FINISH   = 2'd3
    } state_t;

    // Loop-order encodings. Any other value runs window-major.
    localparam logic [1:0] MODE_WIN_MAJOR  = 2'd0;
    localparam logic [1:0] MODE_FILT_MAJOR = 2'd1;

endpackage

// File: rtl/conv_read_addr_gen_circ_offset.sv
// Purpose : modular add/subtract over a circular buffer of DEPTH entries.
// Latency : combinational.
// Backpressure : n/a.
// Ports: a, b operands (both expected < DEPTH); sub selects a-b (circular
// distance from b to a) versus a+b; y is the result reduced modulo DEPTH.
module circ_offset #(
    parameter int W     = 4,
    parameter int DEPTH = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);

    localparam logic [W:0] DX = (W+1)'(DEPTH);

    logic [W:0] ax;
    logic [W:0] bx;
    logic [W:0] t;

    always_comb begin
        ax = {1'b0, a};
        bx = {1'b0, b};
        t  = '0;
        if (sub) begin
            if (ax >= bx) t = ax - bx;
            else          t = ax + DX - bx;
        end else begin
            t = ax + bx;
        end
        // One correction step is enough while both operands stay below DEPTH.
        if (t >= DX) t = t - DX;
        y = t[W-1:0];
    end

endmodule

// File: rtl/conv_read_addr_gen.sv
// Purpose : walk one IFMap row in the circular scratchpad, issuing paired
//           IFMap/filter read addresses per window x filter x tap.
// Latency : addresses are combinational from counters; valid in the same cycle.
// Backpressure : beats issue only when valid_IF & valid_filter & ~stall;
//           otherwise counters and addresses hold.
// Ports: start latches stride/filter_size/n/mode; start_row/end_row are the
// row FIFO heads (end_row_valid = non-empty); done/start_row_ren/end_row_ren
// pulse together for one cycle when a row completes.
module conv_read_addr_gen
    import conv_read_addr_gen_pkg::*;
#(
    parameter int IFMap_ADDR_WIDTH  = 4,
    parameter int FILTER_ADDR_WIDTH = 4,
    parameter int IFMap_DEPTH       = 12,
    parameter int FILTER_DEPTH      = 16,
    parameter int N_WIDTH           = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic                         valid_IF,
    input  logic                         valid_filter,
    input  logic                         stall,
    input  logic [IFMap_ADDR_WIDTH-1:0]  stride,
    input  logic [FILTER_ADDR_WIDTH-1:0] filter_size,
    input  logic [N_WIDTH-1:0]           n,
    input  logic [1:0]                   mode,
    input  logic [IFMap_ADDR_WIDTH-1:0]  start_row,
    input  logic [IFMap_ADDR_WIDTH-1:0]  end_row,
    input  logic                         end_row_valid,
    output logic                         ren_filter,
    output logic                         valid,
    output logic                         done,
    output logic                         start_row_ren,
    output logic                         end_row_ren,
    output logic [IFMap_ADDR_WIDTH-1:0]  ReadAddrIF,
    output logic [FILTER_ADDR_WIDTH-1:0] ReadAddrFilter
);

    // Wide enough for window + stride + filter_size without overflow.
    localparam int CW = ((IFMap_ADDR_WIDTH > FILTER_ADDR_WIDTH) ?
                         IFMap_ADDR_WIDTH : FILTER_ADDR_WIDTH) + 2;

    state_t state, state_nxt;

    logic [IFMap_ADDR_WIDTH-1:0]  stride_q;
    logic [FILTER_ADDR_WIDTH-1:0] fs_q;
    logic [N_WIDTH-1:0]           n_q;
    logic [1:0]                   mode_q;

    logic [FILTER_ADDR_WIDTH-1:0] tap;
    logic [FILTER_ADDR_WIDTH-1:0] fbase;
    logic [CW-1:0]                win;
    logic [N_WIDTH-1:0]           filt;

    logic [IFMap_ADDR_WIDTH-1:0]  end_off;
    logic [IFMap_ADDR_WIDTH-1:0]  if_off;
    logic [CW-1:0]                row_len;
    logic [CW-1:0]                fs_x;
    logic [CW-1:0]                stride_x;
    logic                         zero_work;
    logic                         last_tap;
    logic                         last_win;
    logic                         last_filt;
    logic                         issue;
    logic                         last_beat;
    logic                         filt_major;

    // Row length from the circular distance between the FIFO heads.
    circ_offset #(.W(IFMap_ADDR_WIDTH), .DEPTH(IFMap_DEPTH)) u_end_off (
        .a   (end_row),
        .b   (start_row),
        .sub (1'b1),
        .y   (end_off)
    );

    // Window offset + tap stays below the row length, hence below DEPTH.
    assign if_off = win[IFMap_ADDR_WIDTH-1:0] + IFMap_ADDR_WIDTH'(tap);

    circ_offset #(.W(IFMap_ADDR_WIDTH), .DEPTH(IFMap_DEPTH)) u_rd_addr (
        .a   (start_row),
        .b   (if_off),
        .sub (1'b0),
        .y   (ReadAddrIF)
    );

    assign ReadAddrFilter = fbase + tap;

    assign row_len    = CW'(end_off) + CW'(1);
    assign fs_x       = CW'(fs_q);
    assign stride_x   = CW'(stride_q);
    assign zero_work  = (fs_q == '0) || (n_q == '0) || (fs_x > row_len);
    assign last_tap   = (tap == fs_q - FILTER_ADDR_WIDTH'(1));
    assign last_win   = (win + stride_x + fs_x) > row_len;
    assign last_filt  = (filt == n_q - N_WIDTH'(1));
    assign filt_major = (mode_q == MODE_FILT_MAJOR);
    assign issue      = (state == RUN) && !zero_work && valid_IF && valid_filter && !stall;
    assign last_beat  = issue && last_tap && last_win && last_filt;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start)         state_nxt = WAIT_ROW;
            WAIT_ROW: if (end_row_valid) state_nxt = RUN;
            RUN:      if (zero_work || last_beat) state_nxt = FINISH;
            FINISH:   state_nxt = WAIT_ROW;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        valid         = issue;
        ren_filter    = issue;
        done          = (state == FINISH);
        start_row_ren = (state == FINISH);
        end_row_ren   = (state == FINISH);
    end

    // Config latch and loop counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stride_q <= '0;
            fs_q     <= '0;
            n_q      <= '0;
            mode_q   <= MODE_WIN_MAJOR;
            tap      <= '0;
            fbase    <= '0;
            win      <= '0;
            filt     <= '0;
        end else begin
            if (state == IDLE && start) begin
                stride_q <= (stride == '0) ? IFMap_ADDR_WIDTH'(1) : stride;
                fs_q     <= filter_size;
                n_q      <= n;
                mode_q   <= mode;
            end
            // Counters return to zero when a row begins and after its last beat,
            // so ReadAddrIF rests on start_row between rows.
            if ((state == WAIT_ROW && end_row_valid) || last_beat) begin
                tap   <= '0;
                fbase <= '0;
                win   <= '0;
                filt  <= '0;
            end else if (issue) begin
                if (!last_tap) begin
                    tap <= tap + FILTER_ADDR_WIDTH'(1);
                end else begin
                    tap <= '0;
                    if (filt_major) begin
                        if (!last_win) begin
                            win <= win + stride_x;
                        end else begin
                            win   <= '0;
                            filt  <= filt + N_WIDTH'(1);
                            fbase <= fbase + fs_q;
                        end
                    end else begin
                        if (!last_filt) begin
                            filt  <= filt + N_WIDTH'(1);
                            fbase <= fbase + fs_q;
                        end else begin
                            filt  <= '0;
                            fbase <= '0;
                            win   <= win + stride_x;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_read_addr_gen.sv
module tb_conv_read_addr_gen;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       valid_IF;
    logic       valid_filter;
    logic       stall;
    logic [3:0] stride;
    logic [3:0] filter_size;
    logic [3:0] n;
    logic [1:0] mode;
    logic [3:0] start_row;
    logic [3:0] end_row;
    logic       end_row_valid;
    logic       ren_filter;
    logic       valid;
    logic       done;
    logic       start_row_ren;
    logic       end_row_ren;
    logic [3:0] ReadAddrIF;
    logic [3:0] ReadAddrFilter;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int a;
        int fa;
    } beat_t;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    conv_read_addr_gen dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .valid_IF       (valid_IF),
        .valid_filter   (valid_filter),
        .stall          (stall),
        .stride         (stride),
        .filter_size    (filter_size),
        .n              (n),
        .mode           (mode),
        .start_row      (start_row),
        .end_row        (end_row),
        .end_row_valid  (end_row_valid),
        .ren_filter     (ren_filter),
        .valid          (valid),
        .done           (done),
        .start_row_ren  (start_row_ren),
        .end_row_ren    (end_row_ren),
        .ReadAddrIF     (ReadAddrIF),
        .ReadAddrFilter (ReadAddrFilter)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Expected beat list straight from the loop-nest definition.
    function automatic void build(input int sr, input int er, input int fs,
                                  input int st, input int nn, input int md);
        int len;
        int s;
        int wins[$];
        beat_t b;
        exp_q.delete();
        len = ((er >= sr) ? (er - sr) : (er + 12 - sr)) + 1;
        s   = (st == 0) ? 1 : st;
        if (fs == 0 || nn == 0 || fs > len) return;
        for (int w = 0; w + fs <= len; w += s) wins.push_back(w);
        if (md == 1) begin
            for (int f = 0; f < nn; f++)
                foreach (wins[k])
                    for (int i = 0; i < fs; i++) begin
                        b.a  = (sr + wins[k] + i) % 12;
                        b.fa = (f * fs + i) % 16;
                        exp_q.push_back(b);
                    end
        end else begin
            foreach (wins[k])
                for (int f = 0; f < nn; f++)
                    for (int i = 0; i < fs; i++) begin
                        b.a  = (sr + wins[k] + i) % 12;
                        b.fa = (f * fs + i) % 16;
                        exp_q.push_back(b);
                    end
        end
    endfunction

    // Reset, check idle outputs, then start with a new configuration.
    // Returns at a falling edge with the DUT in WAIT_ROW.
    task automatic do_reset(input int fs, input int st, input int nn, input int md);
        @(negedge clk);
        rstn = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_ren", ren_filter, 0);
        chk("rst_done", done, 0);
        chk("rst_pops", {start_row_ren, end_row_ren}, 0);
        chk("rst_addr_if", ReadAddrIF, start_row);
        chk("rst_addr_f", ReadAddrFilter, 0);
        @(negedge clk);
        rstn        = 1'b1;
        filter_size = fs[3:0];
        stride      = st[3:0];
        n           = nn[3:0];
        mode        = md[1:0];
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One row: enters at a falling edge in WAIT_ROW, leaves in the next WAIT_ROW.
    // gmode 0: gates open, 1: random gating, 2: directed stall/valid pattern.
    task automatic do_row(input int sr, input int er, input int gmode, input int erv_delay);
        int idx;
        int cyc;
        logic exp_iss;
        logic pending;
        start_row = sr[3:0];
        end_row   = er[3:0];
        build(sr, er, filter_size, stride, n, mode);
        valid_IF = 1'b1; valid_filter = 1'b1; stall = 1'b0;
        end_row_valid = 1'b0;
        for (int k = 0; k < erv_delay; k++) begin
            #1;
            chk("hold_valid", valid, 0);
            @(negedge clk);
        end
        end_row_valid = 1'b1;
        #1;
        chk("wait_valid", valid, 0);
        chk("wait_done", done, 0);
        @(negedge clk);
        idx = 0;
        cyc = 0;
        do begin
            if (gmode == 1 && cyc < 200) begin
                valid_IF     = ($urandom_range(0, 3) != 0);
                valid_filter = ($urandom_range(0, 3) != 0);
                stall        = ($urandom_range(0, 3) == 0);
            end else if (gmode == 2) begin
                valid_filter = !(cyc >= 2 && cyc <= 4);
                stall        = (cyc == 6 || cyc == 8);
                valid_IF     = (cyc != 10);
            end else begin
                valid_IF = 1'b1; valid_filter = 1'b1; stall = 1'b0;
            end
            #1;
            pending = (idx < exp_q.size());
            exp_iss = pending && valid_IF && valid_filter && !stall;
            chk("valid", valid, exp_iss);
            chk("ren_filter", ren_filter, exp_iss);
            chk("run_done", done, 0);
            if (pending) begin
                chk("addr_if", ReadAddrIF, exp_q[idx].a);
                chk("addr_f", ReadAddrFilter, exp_q[idx].fa);
            end
            if (exp_iss) idx++;
            cyc++;
            @(negedge clk);
        end while (idx < exp_q.size());
        valid_IF = 1'b1; valid_filter = 1'b1; stall = 1'b0;
        #1;
        chk("fin_done", done, 1);
        chk("fin_start_pop", start_row_ren, 1);
        chk("fin_end_pop", end_row_ren, 1);
        chk("fin_valid", valid, 0);
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0;
        valid_IF = 1'b0; valid_filter = 1'b0; stall = 1'b0;
        stride = 4'd0; filter_size = 4'd0; n = 4'd0; mode = 2'd0;
        start_row = 4'd0; end_row = 4'd0; end_row_valid = 1'b0;

        // Basic row, stride 4, then stride 2 and a wrapped row with a late end_row_valid.
        do_reset(4, 4, 1, 0);
        do_row(0, 7, 0, 0);
        do_reset(4, 2, 1, 0);
        do_row(0, 7, 0, 0);
        do_row(10, 3, 0, 2);

        // Two filters, both loop orders, then mode 3 and stride 0.
        do_reset(2, 2, 2, 0);
        do_row(0, 3, 0, 0);
        do_reset(2, 2, 2, 1);
        do_row(0, 3, 0, 0);
        do_reset(2, 0, 2, 3);
        do_row(4, 8, 0, 0);

        // Directed stall / valid_filter holes mid-window.
        do_reset(4, 2, 2, 0);
        do_row(5, 4, 2, 0);
        do_row(1, 6, 2, 1);

        // Zero work: taps longer than row, no filters, no taps.
        do_reset(9, 1, 1, 0);
        do_row(0, 7, 0, 0);
        do_reset(2, 1, 0, 1);
        do_row(3, 6, 0, 0);
        do_reset(0, 1, 2, 0);
        do_row(3, 6, 0, 0);

        // Randomized configurations and rows.
        for (int r = 0; r < 8; r++) begin
            do_reset($urandom_range(1, 5), $urandom_range(0, 3),
                     $urandom_range(1, 3), $urandom_range(0, 3));
            do_row($urandom_range(0, 11), $urandom_range(0, 11), 1, $urandom_range(0, 1));
            do_row($urandom_range(0, 11), $urandom_range(0, 11), 1, 0);
        end

        // Asynchronous reset in the middle of a row.
        do_reset(4, 2, 1, 0);
        start_row = 4'd2; end_row = 4'd9;
        end_row_valid = 1'b1;
        valid_IF = 1'b1; valid_filter = 1'b1; stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_valid", valid, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_ren", ren_filter, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_pops", {start_row_ren, end_row_ren}, 0);
        chk("mid_rst_addr_if", ReadAddrIF, start_row);
        chk("mid_rst_addr_f", ReadAddrFilter, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("idle_valid", valid, 0);
            chk("idle_done", done, 0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
